// File: rtl/parallel_to_serial_pkg.sv
// Shared types and sizing helpers for the parallel_to_serial block.
package parallel_to_serial_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  // Bit counter width: $clog2(width), but never narrower than one bit.
  function automatic int cnt_width(input int w);
    return ($clog2(w) > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/p2s_hold_reg.sv
// One-entry valid/ready holding register; ready means the entry is empty.
module p2s_hold_reg #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data
);

  logic             full;
  logic [width-1:0] data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
      data <= in_data;
    end else if (out_ready && full) begin
      full <= 1'b0;
    end
  end

  assign in_ready  = ~full;
  assign out_valid = full;
  assign out_data  = data;

endmodule

// File: rtl/parallel_to_serial.sv
// Parallel word to LSB-first serial stream with valid/last framing.
// Optional one-word holding register: define PARALLEL_TO_SERIAL_DOUBLE_BUF_EN.
module parallel_to_serial
  import parallel_to_serial_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  input  logic [width-1:0] parallel_data,
  output logic             parallel_ready,
  output logic             serial_valid,
  output logic             serial_data,
  output logic             serial_last,
  output logic             busy
);

  localparam int            CW       = cnt_width(width);
  localparam logic [CW-1:0] LAST_BIT = CW'(width - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [width-1:0] shreg;
  logic             at_last, free, load, hold_full;
  logic [width-1:0] load_data;

  // cnt is the index of the bit currently on serial_data
  assign at_last = (state == SHIFT) && (cnt == LAST_BIT);
  assign free    = (state == IDLE) || at_last;

`ifdef PARALLEL_TO_SERIAL_DOUBLE_BUF_EN
  logic             hold_ready, hold_in_valid;
  logic [width-1:0] hold_data;

  assign parallel_ready = ~rst & hold_ready;
  // A word bypasses the holding register when the shifter is free and nothing is queued.
  assign hold_in_valid  = parallel_valid & ~(free & ~hold_full);
  assign load           = free & (hold_full | (parallel_valid & parallel_ready));
  assign load_data      = hold_full ? hold_data : parallel_data;

  p2s_hold_reg #(.width(width)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (hold_in_valid),
    .in_ready  (hold_ready),
    .in_data   (parallel_data),
    .out_valid (hold_full),
    .out_ready (free),
    .out_data  (hold_data)
  );
`else
  assign parallel_ready = ~rst & free;
  assign load           = parallel_valid & parallel_ready;
  assign load_data      = parallel_data;
  assign hold_full      = 1'b0;
`endif

  assign busy = (state == SHIFT) | hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      serial_valid <= 1'b0;
      serial_data  <= 1'b0;
      serial_last  <= 1'b0;
    end else if (load) begin
      state        <= SHIFT;
      cnt          <= '0;
      shreg        <= load_data >> 1;
      serial_valid <= 1'b1;
      serial_data  <= load_data[0];
      serial_last  <= (width == 1);
    end else if (at_last) begin
      state        <= IDLE;
      cnt          <= '0;
      serial_valid <= 1'b0;
      serial_data  <= 1'b0;
      serial_last  <= 1'b0;
    end else if (state == SHIFT) begin
      cnt          <= cnt + 1'b1;
      shreg        <= shreg >> 1;
      serial_data  <= shreg[0];
      serial_last  <= (cnt == LAST_BIT - 1'b1);
    end
  end

endmodule

// File: doc/parallel_to_serial.md
PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 Parameter width SHALL be declared as: width, 8, number of bits per parallel word; legal range is 1 and above.
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state updates occur on the rising edge.
REQ-003 Port rst SHALL be: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port parallel_valid SHALL be: parallel_valid  input  1  upstream word available.
REQ-005 Port parallel_data SHALL be: parallel_data  input  width  upstream word.
REQ-006 Port parallel_ready SHALL be: parallel_ready  output  1  block can accept a word this cycle.
REQ-007 Port serial_valid SHALL be: serial_valid  output  1  serial_data carries a valid bit; feeds serial_to_parallel.serial_valid.
REQ-008 Port serial_data SHALL be: serial_data  output  1  current bit; feeds serial_to_parallel.serial_data.
REQ-009 Port serial_last SHALL be: serial_last  output  1  current bit is bit width-1 of its word.
REQ-010 Port busy SHALL be: busy  output  1  a word is being shifted or is held.

Function
REQ-011 A word SHALL be accepted on any rising edge where parallel_valid and parallel_ready are both 1; parallel_data is sampled at that edge.
REQ-012 Bits SHALL be emitted LSB first, one per cycle, with no gaps, so that serial_to_parallel rebuilds the original word.
REQ-013 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-014 IDLE to SHIFT SHALL occur on acceptance; SHIFT to IDLE SHALL occur after bit width-1 is emitted when no next word is available.
REQ-015 Latency SHALL be: for a word accepted at edge N, bit 0 appears in the cycle after edge N, and bit width-1 appears in the cycle after edge N+width-1.
REQ-016 serial_valid, serial_data and serial_last SHALL be registered outputs.
REQ-017 serial_last SHALL be 1 only together with serial_valid on bit width-1.
REQ-018 The bit counter SHALL be $clog2(width) bits wide (minimum 1), SHALL count 0..width-1, and SHALL wrap to 0 after bit width-1.
REQ-019 parallel_ready SHALL be 1 in IDLE and in the SHIFT cycle that emits bit width-1, and 0 otherwise (without the buffer option).
REQ-020 If a word is accepted in the bit width-1 cycle, the next word's bit 0 SHALL follow in the very next cycle with no idle cycle between words.
REQ-021 For width=1, every valid bit SHALL carry serial_last=1, and parallel_ready SHALL stay 1 during a continuous stream.
REQ-022 While SHIFT is active, changes on parallel_data SHALL NOT affect emitted bits.
REQ-023 busy SHALL be 1 whenever the state is SHIFT or the holding register is full.

Reset
REQ-024 While rst is 1, serial_valid, serial_data, serial_last, busy and parallel_ready SHALL all be 0.
REQ-025 While rst is 1, the state SHALL be IDLE, the counter 0, and all data registers 0.
REQ-026 Reset asserted mid-word SHALL abort the word immediately; the remaining bits SHALL never be emitted.
REQ-027 parallel_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 Macro PARALLEL_TO_SERIAL_DOUBLE_BUF_EN SHALL, when defined, add a one-entry holding register; parallel_ready then equals "holding register empty", including during SHIFT.
REQ-029 With PARALLEL_TO_SERIAL_DOUBLE_BUF_EN defined, a held word SHALL move into the shifter in the bit width-1 cycle, giving a gapless stream.
REQ-030 With PARALLEL_TO_SERIAL_DOUBLE_BUF_EN undefined, there SHALL be no holding register, and REQ-019 applies.

Structure
REQ-031 Package parallel_to_serial_pkg SHALL hold the state enum typedef (IDLE, SHIFT) and the counter-width function max(1, $clog2(width)).
REQ-032 The holding register SHALL be sub-module p2s_hold_reg (valid/ready, one entry), instantiated only under PARALLEL_TO_SERIAL_DOUBLE_BUF_EN.

Verification
REQ-033 Single word: width=8, word 8'hA5 accepted at edge N -> serial_data 1,0,1,0,0,1,0,1 in cycles N+1..N+8, serial_last only at N+8, then IDLE.
REQ-034 Back-to-back: words 8'h3C then 8'hFF, with valid held high -> 16 consecutive valid bits, serial_last at bits 8 and 16, no gap.
REQ-035 Loopback: outputs connected to serial_to_parallel with width=8, 100 random words -> every parallel_data equals its sent word, in order.
REQ-036 Mid-word reset: rst pulsed during bit 3 of 8'hF0 -> all outputs 0 immediately; the next accepted word 8'h0F is emitted complete and correct.
REQ-037 Backpressure (macro undefined): parallel_valid held high -> parallel_ready high only in IDLE and bit-7 cycles; with the macro defined, ready is high at bit 1 and a second word is held.
REQ-038 width=1: stream 1,0,1 -> three consecutive valid bits, each with serial_last=1.
